// File: rtl/pixel_array_ctrl.sv
// rtl/pixel_array_ctrl.sv - erase/expose/ramp/readout sequencer for the 2x2 pixel array
// Outputs are registered from the next-state decode so they always match the current state.
module pixel_array_ctrl #(
  parameter int ERASE_CYCLES   = 5,
  parameter int EXPOSE_CYCLES  = 255,
  parameter int CONVERT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       erase,
  output logic       ana_reset,
  output logic       expose,
  output logic       ana_ramp,
  output logic       read1,
  output logic       read2,
  output logic [7:0] pix_data_drv,
  output logic       pix_data_oe,
  input  logic [7:0] pix_data1_in,
  input  logic [7:0] pix_data2_in,
  output logic [7:0] out_data,
  output logic [1:0] out_index,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_ERASE   = 4'd1;
  localparam logic [3:0] S_EXPOSE  = 4'd2;
  localparam logic [3:0] S_CONVERT = 4'd3;
  localparam logic [3:0] S_TURN    = 4'd4;
  localparam logic [3:0] S_RSETTLE = 4'd5;
  localparam logic [3:0] S_RCAPT   = 4'd6;
  localparam logic [3:0] S_OUT0    = 4'd7;
  localparam logic [3:0] S_OUT1    = 4'd8;

  localparam int CW = 16;
  localparam logic [CW-1:0] ERASE_LAST   = CW'(ERASE_CYCLES - 1);
  localparam logic [CW-1:0] EXPOSE_LAST  = CW'(EXPOSE_CYCLES - 1);
  localparam logic [CW-1:0] CONVERT_LAST = CW'(CONVERT_CYCLES - 1);

  logic [3:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          row, row_n;
  logic [7:0]    p_b;
  logic          last_q;
  logic          accept;
  logic          out_n;

  assign accept     = out_valid & out_ready;
  // Combinational in out_ready so the pulse lands on the accepting cycle itself.
  assign frame_done = last_q & accept;
  assign out_n      = (state_n == S_OUT0) || (state_n == S_OUT1);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    row_n   = row;
    case (state)
      S_IDLE: if (start) begin
        state_n = S_ERASE;
        cnt_n   = '0;
        row_n   = 1'b0;
      end
      S_ERASE:
        if (cnt == ERASE_LAST) begin state_n = S_EXPOSE; cnt_n = '0; end
        else cnt_n = cnt + 1'b1;
      S_EXPOSE:
        if (cnt == EXPOSE_LAST) begin state_n = S_CONVERT; cnt_n = '0; end
        else cnt_n = cnt + 1'b1;
      S_CONVERT:
        if (cnt == CONVERT_LAST) begin state_n = S_TURN; cnt_n = '0; end
        else cnt_n = cnt + 1'b1;
      S_TURN:    state_n = S_RSETTLE;
      S_RSETTLE: state_n = S_RCAPT;
      S_RCAPT:   state_n = S_OUT0;
      S_OUT0:    if (accept) state_n = S_OUT1;
      S_OUT1: if (accept) begin
        if (row) state_n = S_IDLE;
        else begin
          state_n = S_RSETTLE;
          row_n   = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      row          <= 1'b0;
      p_b          <= 8'h00;
      last_q       <= 1'b0;
      erase        <= 1'b0;
      ana_reset    <= 1'b0;
      expose       <= 1'b0;
      ana_ramp     <= 1'b0;
      read1        <= 1'b0;
      read2        <= 1'b0;
      pix_data_drv <= 8'h00;
      pix_data_oe  <= 1'b0;
      out_data     <= 8'h00;
      out_index    <= 2'd0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      row          <= row_n;
      if (state == S_RCAPT) p_b <= pix_data2_in;
      last_q       <= (state_n == S_OUT1) && row_n;
      erase        <= (state_n == S_ERASE);
      ana_reset    <= (state_n == S_ERASE);
      expose       <= (state_n == S_EXPOSE);
      ana_ramp     <= (state_n == S_CONVERT);
      pix_data_oe  <= (state_n == S_CONVERT);
      pix_data_drv <= (state_n == S_CONVERT) ? cnt_n[7:0] : 8'h00;
      read1        <= ((state_n == S_RSETTLE) || (state_n == S_RCAPT)) && !row_n;
      read2        <= ((state_n == S_RSETTLE) || (state_n == S_RCAPT)) && row_n;
      out_valid    <= out_n;
      out_index    <= out_n ? {row_n, state_n == S_OUT1} : 2'd0;
      // Bus 1 is taken straight off the capture edge; bus 2 waits in p_b for OUT1.
      if (state_n == S_OUT0)      out_data <= (state == S_RCAPT) ? pix_data1_in : out_data;
      else if (state_n == S_OUT1) out_data <= p_b;
      else                        out_data <= 8'h00;
      busy         <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// tb/tb_pixel_array_ctrl.sv - scoreboard bench for pixel_array_ctrl
module tb_pixel_array_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       out_ready = 1'b1;
  logic       erase, ana_reset, expose, ana_ramp, read1, read2, pix_data_oe;
  logic       out_valid, busy, frame_done;
  logic [7:0] pix_data_drv, out_data, pix_data1_in, pix_data2_in;
  logic [1:0] out_index;

  logic       start2 = 1'b0;
  logic       ready2 = 1'b1;
  logic       erase2, ana_reset2, expose2, ana_ramp2, read1_2, read2_2, oe2;
  logic       valid2, busy2, done2;
  logic [7:0] drv2, data2, bus1_2, bus2_2;
  logic [1:0] index2;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int erase_run = 0, expose_run = 0, oe_run = 0, exp_drv = 0, turn_stage = 0;
  logic [9:0] sb[$];

  always #5 clk = ~clk;

  assign pix_data1_in = read1 ? 8'h11 : (read2 ? 8'h33 : 8'h00);
  assign pix_data2_in = read1 ? 8'h22 : (read2 ? 8'h44 : 8'h00);
  assign bus1_2 = read1_2 ? 8'h55 : (read2_2 ? 8'h77 : 8'h00);
  assign bus2_2 = read1_2 ? 8'h66 : (read2_2 ? 8'h88 : 8'h00);

  pixel_array_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .erase(erase), .ana_reset(ana_reset),
    .expose(expose), .ana_ramp(ana_ramp), .read1(read1), .read2(read2),
    .pix_data_drv(pix_data_drv), .pix_data_oe(pix_data_oe),
    .pix_data1_in(pix_data1_in), .pix_data2_in(pix_data2_in),
    .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .frame_done(frame_done)
  );

  pixel_array_ctrl #(.ERASE_CYCLES(2), .EXPOSE_CYCLES(3), .CONVERT_CYCLES(256)) dut256 (
    .clk(clk), .reset(reset), .start(start2), .erase(erase2), .ana_reset(ana_reset2),
    .expose(expose2), .ana_ramp(ana_ramp2), .read1(read1_2), .read2(read2_2),
    .pix_data_drv(drv2), .pix_data_oe(oe2),
    .pix_data1_in(bus1_2), .pix_data2_in(bus2_2),
    .out_data(data2), .out_index(index2), .out_valid(valid2),
    .out_ready(ready2), .busy(busy2), .frame_done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame;
    sb.push_back({2'd0, 8'h11});
    sb.push_back({2'd1, 8'h22});
    sb.push_back({2'd2, 8'h33});
    sb.push_back({2'd3, 8'h44});
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle;
    int n = 0;
    while ((busy || sb.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    chk("idle_timeout", n >= 3000, 0);
  endtask

  // Protocol monitor and scoreboard for the default-parameter instance.
  always @(negedge clk) begin
    logic [9:0] e;
    if (reset) begin
      erase_run = 0; expose_run = 0; oe_run = 0; exp_drv = 0; turn_stage = 0;
    end else begin
      chk("ana_reset_eq", ana_reset, erase);
      chk("oe_read_excl", pix_data_oe & (read1 | read2), 0);
      chk("read_excl", read1 & read2, 0);
      if (!pix_data_oe) chk("drv_idle", pix_data_drv, 0);
      if (erase) erase_run++;
      else if (erase_run != 0) begin chk("erase_len", erase_run, 5); erase_run = 0; end
      if (expose) expose_run++;
      else if (expose_run != 0) begin chk("expose_len", expose_run, 255); expose_run = 0; end
      if (pix_data_oe) begin
        chk("drv_ramp", pix_data_drv, exp_drv);
        chk("ramp_eq_oe", ana_ramp, 1);
        exp_drv++;
        oe_run++;
      end else if (oe_run != 0) begin
        chk("oe_len", oe_run, 255);
        chk("turn_quiet", {read1, read2}, 0);
        oe_run = 0; exp_drv = 0; turn_stage = 1;
      end else if (turn_stage == 1) begin
        chk("read1_after_turn", read1, 1);
        turn_stage = 0;
      end
      if (frame_done) done_cnt++;
      if (out_valid && sb.size() == 0) chk("unexpected_out", 1, 0);
      else if (out_valid && out_ready) begin
        e = sb.pop_front();
        chk("out_index", out_index, e[9:8]);
        chk("out_data", out_data, e[7:0]);
        chk("frame_done_on_px3", frame_done, e[9:8] == 2'd3);
      end else if (frame_done) chk("frame_done_spurious", 1, 0);
    end
  end

  initial begin
    int n;
    int cnt2;
    logic [7:0] last2;
    bit seen;

    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_erase", erase, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_oe", pix_data_oe, 0);
    chk("rst_done", frame_done, 0);
    reset = 1'b0;
    repeat (3) tick();
    chk("idle_busy", busy, 0);

    // Frame 1: nominal
    push_frame();
    pulse_start();
    chk("erase_start", erase, 1);
    chk("busy_start", busy, 1);
    wait_idle();

    // Frame 2: ignored starts plus backpressure on pixel 1
    push_frame();
    pulse_start();
    n = 0;
    while (!expose && n < 100) begin tick(); n++; end
    chk("wait_expose", expose, 1);
    pulse_start();
    n = 0;
    while (!(out_valid && out_index == 2'd0) && n < 1000) begin tick(); n++; end
    chk("wait_out0", out_valid, 1);
    pulse_start();
    n = 0;
    while (!(out_valid && out_index == 2'd1) && n < 10) begin tick(); n++; end
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_index", out_index, 1);
      chk("stall_data", out_data, 8'h22);
      chk("stall_read2", read2, 0);
      tick();
    end
    out_ready = 1'b1;
    wait_idle();
    repeat (5) tick();
    chk("no_extra_frame", busy, 0);

    // Frame 3 then frame 4 started in the first IDLE cycle after frame_done
    push_frame();
    pulse_start();
    n = 0;
    while (!frame_done && n < 3000) begin tick(); n++; end
    chk("wait_done", frame_done, 1);
    tick();
    chk("busy_drop", busy, 0);
    push_frame();
    pulse_start();
    chk("restart_erase", erase, 1);
    wait_idle();

    // Frame 5: reset during conversion
    push_frame();
    pulse_start();
    n = 0;
    while (!(pix_data_oe && pix_data_drv == 8'h40) && n < 1000) begin tick(); n++; end
    chk("wait_drv40", pix_data_drv, 8'h40);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_oe", pix_data_oe, 0);
    chk("mid_rst_ramp", ana_ramp, 0);
    chk("mid_rst_drv", pix_data_drv, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    sb.delete();
    tick();
    reset = 1'b0;
    repeat (20) tick();
    chk("post_rst_idle", busy, 0);
    push_frame();
    pulse_start();
    wait_idle();
    chk("frame_count", done_cnt, 5);

    // 256-cycle conversion on the second instance
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    cnt2 = 0;
    last2 = 8'h00;
    seen = 1'b0;
    n = 0;
    while (n < 2000) begin
      tick();
      n++;
      if (oe2) begin
        chk("drv256_ramp", drv2, cnt2[7:0]);
        last2 = drv2;
        cnt2++;
        seen = 1'b1;
      end else if (seen) break;
    end
    chk("oe256_len", cnt2, 256);
    chk("drv256_last", last2, 8'hFF);
    chk("drv256_after", drv2, 0);
    n = 0;
    while (busy2 && n < 100) begin tick(); n++; end
    chk("busy256_idle", busy2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
